// File: rtl/usb_pkg.sv
// USB transmit packetizer shared definitions.
// PID values, CRC16 constants and FSM state encoding.
package usb_pkg;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_NYET  = 8'h96;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_DATA2 = 8'h87;
  localparam logic [7:0] PID_MDATA = 8'h0F;

  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_SEND_PID,
    ST_FETCH,
    ST_SEND_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_FAIL
  } state_t;

  // Check field must be the complement of the type field and the
  // PID must be a handshake (x10) or data (x11) packet.
  function automatic logic pid_ok(input logic [7:0] pid);
    return (pid[7:4] == ~pid[3:0]) && pid[1];
  endfunction

  function automatic logic pid_is_hs(input logic [7:0] pid);
    return pid[1:0] == 2'b10;
  endfunction

endpackage

// File: rtl/usb_tx_packetizer_if.sv
// Byte-wide PHY transmit port.
// master drives bytes toward the PHY, slave is the PHY side.
interface usb_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_abort;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready,
    input  tx_abort
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready,
    output tx_abort
  );
endinterface

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 update, reflected polynomial.
// Bits of the byte are folded in LSB first.
module usb_crc16
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // Eight unrolled serial steps of the reflected CRC.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i])
        crc_out = (crc_out >> 1) ^ CRC16_POLY;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/usb_tx_packetizer.sv
// Endpoint byte stream to USB packet on the PHY TX port.
// Checks the PID, appends CRC16 to data packets.
module usb_tx_packetizer
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] data_i,
  input  logic       data_i_start_stop,
  output logic       data_i_strb,
  output logic       data_i_fail,
  usb_tx_if.master   tx,
  output logic       busy
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;
  logic [7:0] pid_q, pid_d;
  logic [7:0] byte_q, byte_d;
  logic [15:0] crc_q, crc_d, crc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic strb_q, strb_d;
  logic fail_q, fail_d;
  logic tx_valid_q, tx_valid_d;
  logic tx_last_q, tx_last_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic busy_q, busy_d;
  logic ss;
  logic accept;

  assign ss = data_i_start_stop;
  assign accept = tx_valid_q & tx.tx_ready;

  usb_crc16 u_crc (
    .crc_in (crc_q),
    .data   (data_i),
    .crc_out(crc_nxt)
  );

  // Next state and datapath; PHY abort overrides everything.
  always_comb begin
    state_d = state_q;
    pid_d = pid_q;
    byte_d = byte_q;
    crc_d = crc_q;
    cnt_d = cnt_q;
    strb_d = 1'b0;
    if (tx.tx_abort && state_q != ST_IDLE) begin
      state_d = ST_FAIL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss) begin
            pid_d = data_i;
            strb_d = 1'b1;
            crc_d = CRC16_INIT;
            cnt_d = '0;
            state_d = pid_ok(data_i) ? ST_SEND_PID : ST_FAIL;
          end
        end
        ST_SEND_PID: begin
          if (accept)
            state_d = pid_is_hs(pid_q) ? ST_IDLE : ST_FETCH;
        end
        ST_FETCH: begin
          if (!ss) begin
            state_d = ST_CRC_LO;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_FAIL;
          end else begin
            byte_d = data_i;
            strb_d = 1'b1;
            crc_d = crc_nxt;
            cnt_d = cnt_q + CNT_ONE;
            state_d = ST_SEND_DATA;
          end
        end
        ST_SEND_DATA: if (accept) state_d = ST_FETCH;
        ST_CRC_LO:    if (accept) state_d = ST_CRC_HI;
        ST_CRC_HI:    if (accept) state_d = ST_IDLE;
        ST_FAIL:      if (!ss) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs derived from the state being entered, so they register cleanly.
  always_comb begin
    tx_valid_d = 1'b1;
    tx_last_d = 1'b0;
    tx_data_d = '0;
    unique case (1'b1)
      state_d == ST_SEND_PID: begin
        tx_data_d = pid_d;
        tx_last_d = pid_is_hs(pid_d);
      end
      state_d == ST_SEND_DATA: tx_data_d = byte_d;
      state_d == ST_CRC_LO:    tx_data_d = ~crc_d[7:0];
      state_d == ST_CRC_HI: begin
        tx_data_d = ~crc_d[15:8];
        tx_last_d = 1'b1;
      end
      default: tx_valid_d = 1'b0;
    endcase
    fail_d = (state_d == ST_FAIL) && (state_q != ST_FAIL);
    busy_d = state_d != ST_IDLE;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      pid_q <= '0;
      byte_q <= '0;
      crc_q <= CRC16_INIT;
      cnt_q <= '0;
      strb_q <= 1'b0;
      fail_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q <= 1'b0;
      tx_data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q <= pid_d;
      byte_q <= byte_d;
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      strb_q <= strb_d;
      fail_q <= fail_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q <= tx_last_d;
      tx_data_q <= tx_data_d;
      busy_q <= busy_d;
    end
  end

  assign data_i_strb = strb_q;
  assign data_i_fail = fail_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_last = tx_last_q;
  assign tx.tx_data = tx_data_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Testbench for usb_tx_packetizer.
// Endpoint driver, PHY sink and packet-level expectation model.
module tb_usb_tx_packetizer;
  import usb_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic ss = 1'b0;
  logic sel = 1'b0;
  logic rdy = 1'b1;
  logic abt = 1'b0;
  logic mon_en = 1'b0;

  logic strb_a, fail_a, busy_a;
  logic strb_b, fail_b, busy_b;

  always #5 clk = ~clk;

  usb_tx_if ifa ();
  usb_tx_if ifb ();

  assign ifa.tx_ready = rdy;
  assign ifa.tx_abort = abt & ~sel;
  assign ifb.tx_ready = rdy;
  assign ifb.tx_abort = abt & sel;

  usb_tx_packetizer #(.MAX_PAYLOAD(64)) dut_a (
    .clk(clk),
    .nrst(nrst),
    .data_i(data_i),
    .data_i_start_stop(ss & ~sel),
    .data_i_strb(strb_a),
    .data_i_fail(fail_a),
    .tx(ifa),
    .busy(busy_a)
  );

  usb_tx_packetizer #(.MAX_PAYLOAD(4)) dut_b (
    .clk(clk),
    .nrst(nrst),
    .data_i(data_i),
    .data_i_start_stop(ss & sel),
    .data_i_strb(strb_b),
    .data_i_fail(fail_b),
    .tx(ifb),
    .busy(busy_b)
  );

  logic m_valid, m_last, m_strb, m_fail, m_busy;
  logic [7:0] m_data;
  assign m_valid = sel ? ifb.tx_valid : ifa.tx_valid;
  assign m_last = sel ? ifb.tx_last : ifa.tx_last;
  assign m_data = sel ? ifb.tx_data : ifa.tx_data;
  assign m_strb = sel ? strb_b : strb_a;
  assign m_fail = sel ? fail_b : fail_a;
  assign m_busy = sel ? busy_b : busy_a;

  int ncmp = 0;
  int nfail = 0;
  int strb_cnt = 0;
  int fail_cnt = 0;
  logic [8:0] exp_q[$];
  bq_t ep_q;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // USB CRC16 of a payload, already complemented (low byte sent first).
  function automatic logic [15:0] model_crc(input bq_t b);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[k][j];
        c = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
      end
    end
    return ~c;
  endfunction

  // Expected PHY words {last,byte}, strobe and fail counts for ep_q.
  task automatic build_exp(input int maxp, output int e_strb,
                           output int e_fail);
    logic [7:0] pid;
    logic [15:0] c;
    bq_t pl;
    int n;
    exp_q.delete();
    pid = ep_q[0];
    n = ep_q.size() - 1;
    e_strb = 1;
    e_fail = 0;
    if (pid[7:4] != ~pid[3:0] || pid[1] == 1'b0) begin
      e_fail = 1;
    end else if (pid[1:0] == 2'b10) begin
      exp_q.push_back({1'b1, pid});
    end else begin
      exp_q.push_back({1'b0, pid});
      if (n > maxp) begin
        for (int i = 1; i <= maxp; i++) exp_q.push_back({1'b0, ep_q[i]});
        e_strb = 1 + maxp;
        e_fail = 1;
      end else begin
        for (int i = 1; i <= n; i++) begin
          exp_q.push_back({1'b0, ep_q[i]});
          pl.push_back(ep_q[i]);
        end
        c = model_crc(pl);
        exp_q.push_back({1'b0, c[7:0]});
        exp_q.push_back({1'b1, c[15:8]});
        e_strb = n + 1;
      end
    end
  endtask

  // Compare process: PHY bytes, hold rules, abort drop, strobe spacing.
  logic p_valid = 1'b0, p_acc = 1'b0, p_abt = 1'b0, p_busy = 1'b0;
  logic [8:0] p_word = '0;
  logic acc_now;
  int cyc = 0;
  int last_strb = -10;
  always @(negedge clk) begin
    cyc++;
    if (!nrst || !mon_en) begin
      p_valid = 1'b0;
      p_abt = 1'b0;
      p_busy = 1'b0;
    end else begin
      acc_now = m_valid && rdy && !abt;
      if (p_valid && !p_acc && !p_abt) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_word", {23'd0, m_last, m_data}, {23'd0, p_word});
      end
      if (p_abt && p_busy) chk("abort_drop", {31'd0, m_valid}, 32'd0);
      if (m_valid) chk("valid_busy", {31'd0, m_busy}, 32'd1);
      if (acc_now) begin
        if (exp_q.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL tx_byte: got %0h expected no byte",
                   {m_last, m_data});
        end else begin
          chk("tx_byte", {23'd0, m_last, m_data},
              {23'd0, exp_q.pop_front()});
        end
      end
      if (m_strb) begin
        strb_cnt++;
        chk("strb_gap", {31'd0, (cyc - last_strb) >= 2}, 32'd1);
        last_strb = cyc;
      end
      if (m_fail) fail_cnt++;
      p_valid = m_valid;
      p_acc = acc_now;
      p_abt = abt;
      p_busy = m_busy;
      p_word = {m_last, m_data};
    end
  end

  // Endpoint driver for one packet in ep_q, then end-of-packet checks.
  task automatic run_pkt(input string tag, input logic s, input int maxp,
                         input int rmode, input int abort_at,
                         input int strb_ovr, input int hold);
    int e_strb, e_fail, idx, acc, n, k, hcnt;
    logic sv, fv, draining, aborted, fail_seen, done;
    sel = s;
    build_exp(maxp, e_strb, e_fail);
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      e_fail = 1;
      e_strb = strb_ovr;
    end
    n = ep_q.size();
    idx = 0;
    acc = 0;
    hcnt = hold;
    draining = 1'b0;
    aborted = 1'b0;
    fail_seen = 1'b0;
    done = 1'b0;
    @(posedge clk);
    #1;
    strb_cnt = 0;
    fail_cnt = 0;
    mon_en = 1'b1;
    data_i = ep_q[0];
    ss = 1'b1;
    abt = 1'b0;
    rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    k = 0;
    while (!done && k < 400) begin
      k++;
      @(negedge clk);
      sv = m_strb;
      fv = m_fail;
      if (m_valid && rdy && !abt) acc++;
      if (fail_seen && !draining)
        chk({tag, "_fail_hold"}, {31'd0, m_busy}, 32'd1);
      if ((draining || idx >= n) && !m_busy && !ss) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (sv) idx++;
        if (fv) fail_seen = 1'b1;
        if (fail_seen) begin
          if (hcnt > 0) hcnt--;
          else draining = 1'b1;
        end
        ss = !draining && idx < n;
        data_i = (idx < n) ? ep_q[idx] : 8'h00;
        if (rmode != 0) rdy = 1'($urandom_range(0, 1));
        if (abt) aborted = 1'b1;
        abt = !aborted && abort_at >= 0 && acc == abort_at && m_valid;
        if (abt) rdy = 1'b1;
      end
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_left"}, exp_q.size(), 32'd0);
    chk({tag, "_strb"}, strb_cnt, e_strb);
    chk({tag, "_fail"}, fail_cnt, e_fail);
    chk({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
    ss = 1'b0;
    abt = 1'b0;
    rdy = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  int es, ef;
  bq_t pin;

  initial begin
    #2 nrst = 1'b0;
    #10;
    chk("rst_valid_a", {31'd0, ifa.tx_valid}, 32'd0);
    chk("rst_last_a", {31'd0, ifa.tx_last}, 32'd0);
    chk("rst_data_a", {24'd0, ifa.tx_data}, 32'd0);
    chk("rst_strb_a", {31'd0, strb_a}, 32'd0);
    chk("rst_fail_a", {31'd0, fail_a}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_valid_b", {31'd0, ifb.tx_valid}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    @(posedge clk);
    #1 nrst = 1'b1;

    pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("pin_crc_check", {16'd0, model_crc(pin)}, 32'hB4C8);
    pin.delete();
    chk("pin_crc_empty", {16'd0, model_crc(pin)}, 32'h0000);
    ep_q = '{PID_DATA0};
    build_exp(64, es, ef);
    chk("pin_zlp_len", exp_q.size(), 32'd3);
    chk("pin_zlp_lo", {23'd0, exp_q[1]}, 32'h000);
    chk("pin_zlp_hi", {23'd0, exp_q[2]}, 32'h100);

    ep_q = '{PID_ACK};
    run_pkt("ack", 1'b0, 64, 0, -1, 0, 0);

    ep_q = '{PID_DATA0};
    run_pkt("zlp", 1'b0, 64, 0, -1, 0, 0);

    ep_q = '{PID_DATA1, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
             8'h38, 8'h39};
    run_pkt("data1", 1'b0, 64, 0, -1, 0, 0);
    run_pkt("data1_rnd", 1'b0, 64, 1, -1, 0, 0);

    ep_q = '{8'hC2, 8'h11, 8'h22};
    run_pkt("badpid", 1'b0, 64, 0, -1, 0, 3);

    ep_q = '{PID_DATA0, 8'h01, 8'h02, 8'h03, 8'h04};
    run_pkt("max4_ok", 1'b1, 4, 1, -1, 0, 0);

    ep_q = '{PID_DATA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_pkt("overlen", 1'b1, 4, 0, -1, 0, 0);

    ep_q = '{PID_DATA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run_pkt("abort", 1'b0, 64, 0, 2, 3, 0);

    ep_q = '{PID_NAK};
    run_pkt("nak", 1'b0, 64, 1, -1, 0, 0);

    sel = 1'b0;
    fail_cnt = 0;
    @(posedge clk);
    #1 abt = 1'b1;
    repeat (3) @(posedge clk);
    #1 abt = 1'b0;
    @(negedge clk);
    chk("idle_abort_fail", fail_cnt, 32'd0);
    chk("idle_abort_busy", {31'd0, m_busy}, 32'd0);

    mon_en = 1'b0;
    @(posedge clk);
    #1;
    data_i = PID_DATA0;
    ss = 1'b1;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", {31'd0, ifa.tx_valid}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, ifa.tx_valid}, 32'd0);
    chk("mid_rst_last", {31'd0, ifa.tx_last}, 32'd0);
    chk("mid_rst_data", {24'd0, ifa.tx_data}, 32'd0);
    chk("mid_rst_strb", {31'd0, strb_a}, 32'd0);
    chk("mid_rst_fail", {31'd0, fail_a}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    ss = 1'b0;
    rdy = 1'b1;
    @(posedge clk);
    #1 nrst = 1'b1;

    ep_q = '{PID_DATA1, 8'h5A};
    run_pkt("post_rst", 1'b0, 64, 0, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
